rx_slot_ctrl: RTL
=================

# rx_slot_ctrl

RX buffer slot scheduler between the RX MAC and the four 8x1024 receive SRAM banks. It hands a free bank to the MAC at each frame start and commits the frame on a good frame end. It exposes full/empty slot state, frame lengths and a release command to the PicoRV over a small Wishbone register window, and drives `rx_irq`. Banks form a 4-entry ring: the MAC fills at `wr_ptr` and the CPU drains at `rd_ptr`.

## Interface
**Parameters**
- `BASE_ADDR`, default 32'h3000_0100: Wishbone base of the 16-byte register window.
- `MAX_LEN`, default 11'd1024: largest committable frame length, in bytes.

**Ports**
- `wb_clk_i` in 1: sole clock. Frame events are already synchronized into this domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `frame_start` in 1: one-cycle pulse, first byte of a frame.
- `frame_end` in 1: one-cycle pulse, frame complete.
- `frame_err` in 1: qualifies `frame_end`; 1 = FCS/RX_ER error.
- `frame_len` in 11: byte count, valid with `frame_end`.
- `wr_bank` out 2: bank the MAC writes. Drives the chip-select decode.
- `wr_bank_v` out 1: bank granted. MAC writes are allowed only while this is 1.
- `rd_bank` out 2: bank presented to the Wishbone read port (= `rd_ptr`).
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone strobe, cycle, write enable.
- `wbs_sel_i` in 4: Wishbone byte selects.
- `wbs_adr_i`, `wbs_dat_i` in 32: Wishbone address and write data.
- `wbs_ack_o` out 1: Wishbone acknowledge.
- `wbs_dat_o` out 32: Wishbone read data.
- `rx_irq` out 1: level interrupt, `irq_en & |full`.

## Operation
**Slot state**
- `full[3:0]`, `len[0..3][10:0]`, `wr_ptr[1:0]`, `rd_ptr[1:0]`, sticky `ovf`, `drop_cnt[7:0]` (saturating), `irq_en`.

**Writer FSM: IDLE, RECV, DROP**
- IDLE, `frame_start`, `!full[wr_ptr]` → RECV. `wr_bank_v`=1.
- IDLE, `frame_start`, `full[wr_ptr]` → DROP. `ovf`=1, `drop_cnt`++.
- RECV, `frame_end`, good frame → IDLE, committed. Good means `!frame_err && frame_len!=0 && frame_len<=MAX_LEN`.
  - Commit sets `full[wr_ptr]`=1, `len[wr_ptr]`=`frame_len`, `wr_ptr`++ (mod 4).
  - `wr_bank_v`=0.
- RECV, `frame_end`, bad frame → IDLE. Slot is not committed and `wr_ptr` is unchanged; `drop_cnt`++.
- RECV, `frame_start` with no prior `frame_end` → stay in RECV on the same bank. The previous partial frame is abandoned and `drop_cnt`++.
- DROP, `frame_end` → IDLE.
- DROP, `frame_start` → stay in DROP, `drop_cnt`++.
- `frame_start` and `frame_end` in the same cycle: `frame_end` is processed first, then `frame_start` is evaluated against the updated state.

**Registers** (word select `wbs_adr_i[3:2]`, decoded when `wbs_adr_i[31:4]==BASE_ADDR[31:4]`)
- 0x0 STATUS (RO):
  - [3:0] `full`
  - [5:4] `rd_ptr`
  - [7:6] `wr_ptr`
  - [8] `ovf`
  - [9] `irq_en`
  - [23:16] `drop_cnt`
- 0x4 RXLEN (RO): [10:0] `len[rd_ptr]`. Reads 0 when `!full[rd_ptr]`.
- 0x8 CTRL (WO, all bits self-clear):
  - bit0 RELEASE: if `full[rd_ptr]`, clear it and `rd_ptr`++; otherwise ignored.
  - bit1 CLR_OVF: clears `ovf` and `drop_cnt`.
- 0xC IRQ_EN (RW): bit0 `irq_en`.
- Writes take effect only when `wbs_sel_i[0]`=1. Unmapped offsets read 0 and writes are ignored.

**Simultaneous events**
- Commit and RELEASE in the same cycle: both apply.
- When both touch `ovf`/`drop_cnt`, the event increment wins over CLR_OVF.

**Reset values**
- `full`=0, both pointers=0, `ovf`=0, `drop_cnt`=0, `irq_en`=0, FSM=IDLE.
- All outputs 0.
- Reset mid-frame drops the grant immediately (async).

## Timing
- `wr_bank_v` and `wr_bank` are registered and go high the cycle after `frame_start`. The MAC delays its first write by ≥1 cycle.
- The commit is visible in STATUS and `rx_irq` the cycle after `frame_end`.
- Wishbone:
  - `wbs_ack_o` is a single-cycle pulse, one cycle after `stb&cyc` is first seen. It is not reasserted while `stb` stays high past the ack.
  - `wbs_dat_o` is valid with ack.
  - Register side effects occur on the ack cycle.
- `rd_bank` updates the cycle after RELEASE. The SRAM read port has 1 more cycle of latency.
- `rx_irq` deasserts the cycle after RELEASE of the last full slot.

## Test plan
- **Reset:** hold `rst_n`=0 mid-RECV → `wr_bank_v`=0 immediately. After release, STATUS reads 0x0.
- **Single frame:**
  - `irq_en`=1, `frame_start`, 64-byte good `frame_end` → STATUS `full`=0001, `wr_ptr`=1, RXLEN=64, `rx_irq`=1.
  - RELEASE → `rx_irq`=0, `rd_ptr`=1.
- **Overflow:** commit 4 good frames, then a 5th → FSM enters DROP, `ovf`=1, `drop_cnt`=1, `wr_bank_v` stays 0, `full`=1111.
- **Bad frames:** `frame_err`=1, then `frame_len`=0, then `frame_len`=1025 → no commit, `wr_ptr`=0, `drop_cnt`=3.
- **Wrap-around:** 6 frames interleaved with releases → pointers wrap 3→0, each RXLEN matches the length sent.
- **Simultaneous:** commit and RELEASE in the same cycle with `full`=0001 → `full`=0010, `rd_ptr`=1, `wr_ptr`=2. Also `frame_end`+`frame_start` in one cycle → second frame granted on the next bank.

Source files
------------

// File: rtl/rx_slot_ctrl.sv
// RX buffer slot scheduler: hands free SRAM banks to the MAC per frame, commits
// good frames into a 4-entry ring and exposes slot state over a Wishbone window.
module rx_slot_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
  parameter logic [10:0] MAX_LEN   = 11'd1024
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        frame_err,
  input  logic [10:0] frame_len,
  output logic [1:0]  wr_bank,
  output logic        wr_bank_v,
  output logic [1:0]  rd_bank,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        rx_irq
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t           state, state_n, post_end;
  logic [3:0]       full, full_c, commit_mask, rel_mask;
  logic [3:0][10:0] len;
  logic [1:0]       wr_ptr, wr_ptr_c, rd_ptr;
  logic             ovf, irq_en;
  logic [7:0]       drop_cnt;
  logic [8:0]       drop_sum;
  logic             good, commit, ovf_set;
  logic [1:0]       inc;

  logic        hit, req, req_q, access, wr_acc;
  logic        rel_ok, clr_ovf, irq_wr;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign good = !frame_err && (frame_len != 11'd0) && (frame_len <= MAX_LEN);

  // frame_end is resolved first; frame_start then sees the post-commit ring.
  always_comb begin
    state_n  = state;
    post_end = state;
    commit   = 1'b0;
    ovf_set  = 1'b0;
    inc      = 2'd0;
    if (frame_end && state != IDLE) begin
      if (state == RECV) begin
        if (good) commit = 1'b1;
        else      inc    = 2'd1;
      end
      post_end = IDLE;
    end
    commit_mask = commit ? (4'b0001 << wr_ptr) : 4'b0000;
    full_c      = full | commit_mask;
    wr_ptr_c    = wr_ptr + {1'b0, commit};
    state_n     = post_end;
    if (frame_start) begin
      case (post_end)
        IDLE: begin
          if (full_c[wr_ptr_c]) begin
            state_n = DROP;
            ovf_set = 1'b1;
            inc     = inc + 2'd1;
          end else begin
            state_n = RECV;
          end
        end
        default: inc = inc + 2'd1;
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + {7'd0, inc};

  // Wishbone: one access per stb&cyc assertion, acked the following cycle.
  assign hit     = wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign req     = wbs_stb_i && wbs_cyc_i && hit;
  assign access  = req && !req_q;
  assign wr_acc  = access && wbs_we_i && wbs_sel_i[0];
  assign rel_ok  = wr_acc && (wbs_adr_i[3:2] == 2'd2) && wbs_dat_i[0] && full[rd_ptr];
  assign clr_ovf = wr_acc && (wbs_adr_i[3:2] == 2'd2) && wbs_dat_i[1];
  assign irq_wr  = wr_acc && (wbs_adr_i[3:2] == 2'd3);
  assign rel_mask = rel_ok ? (4'b0001 << rd_ptr) : 4'b0000;

  always_comb begin
    rd_mux = 32'd0;
    case (wbs_adr_i[3:2])
      2'd0: rd_mux = {8'd0, drop_cnt, 6'd0, irq_en, ovf, wr_ptr, rd_ptr, full};
      2'd1: rd_mux = full[rd_ptr] ? {21'd0, len[rd_ptr]} : 32'd0;
      2'd3: rd_mux = {31'd0, irq_en};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      full      <= '0;
      len       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
      irq_en    <= 1'b0;
      req_q     <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state  <= state_n;
      if (commit) len[wr_ptr] <= frame_len;
      wr_ptr <= wr_ptr_c;
      full   <= (full | commit_mask) & ~rel_mask;
      if (rel_ok) rd_ptr <= rd_ptr + 2'd1;
      // A same-cycle drop event overrides CLR_OVF.
      if (inc != 2'd0) begin
        ovf      <= ovf | ovf_set;
        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end else if (clr_ovf) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
      if (irq_wr) irq_en <= wbs_dat_i[0];
      req_q     <= req;
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd_mux : 32'd0;
    end
  end

  assign wr_bank   = wr_ptr;
  assign wr_bank_v = (state == RECV);
  assign rd_bank   = rd_ptr;
  assign rx_irq    = irq_en & (|full);

  assign unused_ok = ^{wbs_dat_i[31:2], wbs_adr_i[1:0], wbs_sel_i[3:1]};

endmodule
